// File: rtl/q2_sequencer.sv
// Q2 CPU timing/state sequencer.
// Produces the two-phase machine state bits s0..s3 and the write strobe ws.
// Handles the front-panel controls:
//   - run/stop,
//   - single-step,
//   - deposit, including the P-increment pulse that follows a deposit.
module q2_sequencer #(
   parameter int ALU_STEPS   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run_sw,
   input  logic step_sw,
   input  logic dep_sw_in,
   input  logic o2,
   input  logic deref,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic ws,
   output logic dep_sw,
   output logic incp_db,
   output logic running
);

   localparam int                CNT_W     = $clog2(ALU_STEPS);
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(ALU_STEPS - 1);
   localparam logic [CNT_W-1:0]  PENULT    = CNT_W'(ALU_STEPS - 2);

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_LOAD,
      ST_EXEC,
      ST_ALU
   } state_t;

   state_t               state;
   logic                 phase;
   logic [CNT_W-1:0]     alu_cnt;
   logic [3:0]           s_bits;
   logic                 armed;
   logic                 step_prev;

   logic [SYNC_STAGES-1:0] run_ff;
   logic [SYNC_STAGES-1:0] step_ff;
   logic [SYNC_STAGES-1:0] dep_ff;

   logic run_sync, step_sync, dep_sync;
   logic idle, step_edge, arm_set, enter_fetch, idle_next, dep_next;

   // deref is decoded downstream; the sequence timing never depends on it.
   logic unused_deref;
   assign unused_deref = deref;

   assign run_sync  = run_ff[SYNC_STAGES-1];
   assign step_sync = step_ff[SYNC_STAGES-1];
   assign dep_sync  = dep_ff[SYNC_STAGES-1];

   // Idle means parked in FETCH phase 0 with nothing to do.
   assign idle      = (state == ST_FETCH) && !phase && !running && !armed;
   assign step_edge = step_sync && !step_prev;
   assign arm_set   = idle && step_edge && !dep_sync;

   // The last write phase of EXEC or of the final ALU step returns to FETCH.
   assign enter_fetch = phase &&
                        ((state == ST_EXEC) ||
                         ((state == ST_ALU) && (alu_cnt == LAST_STEP)));

   // Idle-ness of the next cycle.
   // This lets dep_sw be registered yet still equal dep_sync & idle.
   assign idle_next = !run_sync && ((idle && !arm_set) || enter_fetch);
   assign dep_next  = dep_ff[SYNC_STAGES-2] && idle_next;

   // Multi-stage synchronizers for the three raw front-panel switches.
   // NOTE: asynchronous reset in the sensitivity list; sequential state always uses <=.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_ff  <= '0;
         step_ff <= '0;
         dep_ff  <= '0;
      end else begin
         run_ff  <= {run_ff[SYNC_STAGES-2:0],  run_sw};
         step_ff <= {step_ff[SYNC_STAGES-2:0], step_sw};
         dep_ff  <= {dep_ff[SYNC_STAGES-2:0],  dep_sw_in};
      end
   end

   // Sequencer FSM with registered state bits, strobe and front-panel outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_FETCH;
         phase     <= 1'b0;
         alu_cnt   <= '0;
         s_bits    <= 4'b0000;
         running   <= 1'b0;
         armed     <= 1'b0;
         step_prev <= 1'b0;
         dep_sw    <= 1'b0;
         incp_db   <= 1'b0;
      end else begin
         step_prev <= step_sync;
         dep_sw    <= dep_next;
         // The pulse fires only when the deposit ends while still idle.
         incp_db   <= dep_sw && !dep_next && idle_next;

         if ((state == ST_FETCH) && !phase) begin
            if (running || armed) begin
               phase <= 1'b1;
            end else begin
               running <= run_sync;
               if (arm_set) armed <= 1'b1;
            end
         end else if (!phase) begin
            phase <= 1'b1;
         end else begin
            phase <= 1'b0;
            case (state)
               ST_FETCH: begin
                  state  <= ST_DECODE;
                  s_bits <= 4'b0001;
               end
               ST_DECODE: begin
                  if (o2) begin
                     state  <= ST_EXEC;
                     s_bits <= 4'b0011;
                  end else begin
                     state  <= ST_LOAD;
                     s_bits <= 4'b0010;
                  end
               end
               ST_LOAD: begin
                  state   <= ST_ALU;
                  alu_cnt <= '0;
                  s_bits  <= (ALU_STEPS == 1) ? 4'b1000 : 4'b0100;
               end
               ST_ALU: begin
                  if (alu_cnt == LAST_STEP) begin
                     state   <= ST_FETCH;
                     alu_cnt <= '0;
                     s_bits  <= 4'b0000;
                     running <= run_sync;
                     armed   <= 1'b0;
                  end else begin
                     alu_cnt <= alu_cnt + CNT_W'(1);
                     s_bits  <= (alu_cnt == PENULT) ? 4'b1000 : 4'b0100;
                  end
               end
               ST_EXEC: begin
                  state   <= ST_FETCH;
                  s_bits  <= 4'b0000;
                  running <= run_sync;
                  armed   <= 1'b0;
               end
               default: begin
                  state  <= ST_FETCH;
                  s_bits <= 4'b0000;
               end
            endcase
         end
      end
   end

   assign {s3, s2, s1, s0} = s_bits;
   assign ws               = phase;

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed, scoreboard-based bench for q2_sequencer.
// Expected output vectors are queued as stimulus is applied.
// They are checked on the falling clock edge.
module tb_q2_sequencer;

   localparam int ALU_STEPS   = 4;
   localparam int SYNC_STAGES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run_sw = 1'b0, step_sw = 1'b0, dep_sw_in = 1'b0, o2 = 1'b0, deref = 1'b0;
   logic s0, s1, s2, s3, ws, dep_sw, incp_db, running;

   int total = 0;
   int bad   = 0;

   // Each entry is {s3,s2,s1,s0, ws, running, dep_sw, incp_db}.
   logic [7:0] exp_q[$];

   q2_sequencer #(.ALU_STEPS(ALU_STEPS), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst(rst), .run_sw(run_sw), .step_sw(step_sw), .dep_sw_in(dep_sw_in),
      .o2(o2), .deref(deref), .s0(s0), .s1(s1), .s2(s2), .s3(s3), .ws(ws),
      .dep_sw(dep_sw), .incp_db(incp_db), .running(running)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] obs();
      return {s3, s2, s1, s0, ws, running, dep_sw, incp_db};
   endfunction

   function automatic logic [7:0] ent(input logic [3:0] s, input logic w, input logic r,
                                      input logic d, input logic p);
      return {s, w, r, d, p};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Queue the two-phase state/strobe vectors of one instruction.
   task automatic push_instr(input logic op2, input logic run, input int skip);
      logic [7:0] seq[$];
      seq.push_back(ent(4'b0000, 0, run, 0, 0));
      seq.push_back(ent(4'b0000, 1, run, 0, 0));
      seq.push_back(ent(4'b0001, 0, run, 0, 0));
      seq.push_back(ent(4'b0001, 1, run, 0, 0));
      if (op2) begin
         seq.push_back(ent(4'b0011, 0, run, 0, 0));
         seq.push_back(ent(4'b0011, 1, run, 0, 0));
      end else begin
         seq.push_back(ent(4'b0010, 0, run, 0, 0));
         seq.push_back(ent(4'b0010, 1, run, 0, 0));
         for (int k = 0; k < ALU_STEPS; k++) begin
            seq.push_back(ent((k == ALU_STEPS - 1) ? 4'b1000 : 4'b0100, 0, run, 0, 0));
            seq.push_back(ent((k == ALU_STEPS - 1) ? 4'b1000 : 4'b0100, 1, run, 0, 0));
         end
      end
      for (int i = skip; i < seq.size(); i++) exp_q.push_back(seq[i]);
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(ent(4'b0000, 0, 0, 0, 0));
   endtask

   // Compare n queued vectors, one per cycle, starting at the current falling edge.
   task automatic compare_n(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            check({tag, "_underflow"}, 32'd0, 32'd1);
         end else begin
            check(tag, {24'd0, obs()}, {24'd0, exp_q.pop_front()});
         end
         @(negedge clk);
      end
   endtask

   // Bounded wait for a DUT condition.
   // which: 0 = running high, 1 = ws high, 2 = EXEC write phase.
   task automatic wait_cond(input int which, input string tag);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         case (which)
            0:       hit = running;
            1:       hit = ws;
            default: hit = ({s3, s2, s1, s0} == 4'b0011) && ws;
         endcase
      end
      check(tag, {31'd0, hit}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      #12;
      check("reset_outputs", {24'd0, obs()}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("after_release", {24'd0, obs()}, 32'd0);

      // Run with o2=1, then o2=0.
      // Then o2=0 again, with run dropped during ALU step 1.
      run_sw = 1'b1;
      o2     = 1'b1;
      wait_cond(0, "run_start");
      push_instr(1'b1, 1'b1, 0);
      compare_n("run_o2_1", 6);
      o2 = 1'b0;
      push_instr(1'b0, 1'b1, 0);
      compare_n("run_o2_0", 14);
      push_instr(1'b0, 1'b1, 0);
      compare_n("stop_head", 8);
      run_sw = 1'b0;
      compare_n("stop_tail", 6);
      push_idle(12);
      compare_n("stopped_idle", 12);

      // Single step: a long pulse runs one instruction only.
      o2      = 1'b1;
      step_sw = 1'b1;
      wait_cond(1, "step1_start");
      push_instr(1'b1, 1'b0, 1);
      compare_n("step1", 5);
      push_idle(12);
      compare_n("step1_hold", 12);
      step_sw = 1'b0;
      push_idle(4);
      compare_n("step_low", 4);
      step_sw = 1'b1;
      wait_cond(1, "step2_start");
      push_instr(1'b1, 1'b0, 1);
      compare_n("step2", 5);
      step_sw = 1'b0;
      push_idle(6);
      compare_n("step2_idle", 6);

      // Deposit while idle.
      // dep_sw follows after SYNC_STAGES cycles.
      // One incp_db pulse follows its fall.
      dep_sw_in = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         exp_q.push_back(ent(4'b0000, 0, 0, (k >= SYNC_STAGES && k <= SYNC_STAGES + 4),
                             (k == SYNC_STAGES + 5)));
      end
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         check("deposit", {24'd0, obs()}, {24'd0, exp_q.pop_front()});
         if (k == 5) dep_sw_in = 1'b0;
      end

      // Deposit while running is gated off.
      run_sw = 1'b1;
      wait_cond(0, "dep_run_start");
      dep_sw_in = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("dep_run", {30'd0, dep_sw, incp_db}, 32'd0);
         if (k == 4) dep_sw_in = 1'b0;
      end

      // Reset mid-EXEC clears outputs asynchronously.
      // Execution then restarts from FETCH.
      wait_cond(2, "exec_ws");
      #2 rst = 1'b1;
      #1 check("async_reset", {24'd0, obs()}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_cond(0, "restart");
      push_instr(1'b1, 1'b1, 0);
      compare_n("restart_seq", 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/q2_sequencer.md
Name: q2_sequencer

Overview:
- Timing/state sequencer for the Q2 CPU. Generates the state bits s0..s3 and the write strobe ws that the control decoder turns into register/memory strobes.
- Owns front-panel run/stop, single-step and deposit handling, including the incp_db pulse after a deposit.
- Sits between the front-panel switches and the control decoder. Consumes the decoded instruction bits o2 and deref.

Parameters:
- ALU_STEPS, 4: number of serial ALU states per o2=0 instruction; legal values are 2 or more.
- SYNC_STAGES, 2: flip-flop stages on each raw switch input; legal values are 2 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- run_sw  input  1  raw run switch; level, asynchronous
- step_sw  input  1  raw single-step switch; level, asynchronous
- dep_sw_in  input  1  raw deposit switch; level, asynchronous
- o2  input  1  opcode bit 2 from the opcode register; valid from the DECODE state onward
- deref  input  1  indirect bit from the opcode register; valid from the DECODE state onward
- s0, s1, s2, s3  output  1 each  machine state bits
- ws  output  1  write strobe for the current state
- dep_sw  output  1  synchronized, gated deposit request to the control decoder
- incp_db  output  1  one-cycle P-increment pulse after a deposit
- running  output  1  high while instructions are being sequenced

Behaviour:
- Two-phase states:
  - Every machine state lasts exactly 2 clk cycles.
  - Phase 0: ws=0 (settle). Phase 1: ws=1 (write).
  - The state advances on the clk edge that ends phase 1.
- State encoding, written {s3,s2,s1,s0}:
  - FETCH = 0000
  - DECODE/DEREF = 0001
  - LOAD = 0010
  - EXEC = 0011
  - ALU = 01xx-free pattern: {s3,s2,s1,s0} = 0100 for ALU steps 0..ALU_STEPS-2, and 1000 for the final step.
- Transitions:
  - FETCH -> DECODE, always.
  - DECODE -> LOAD if o2=0; DECODE -> EXEC if o2=1. The deref input does not alter the timing of DECODE.
  - LOAD -> ALU step 0.
  - ALU step k -> step k+1. An internal counter of width clog2(ALU_STEPS) tracks k. The final step -> FETCH.
  - EXEC -> FETCH.
- Instruction lengths: o2=1 takes 6 cycles; o2=0 takes 6 + 2*ALU_STEPS cycles (14 at the default).
- Idle condition:
  - The sequencer is idle in FETCH phase 0 with ws=0 whenever running=0 and no step is armed.
  - It leaves idle only when run_sync=1 or a step is armed.
- Run/stop:
  - running = run_sync, sampled only at instruction boundaries (the entry to FETCH phase 0).
  - Deasserting run mid-instruction lets the current instruction complete, then halts at FETCH phase 0.
- Step:
  - A rising edge of the synced step_sw while idle arms exactly one instruction.
  - The arm flag clears on re-entry to FETCH.
  - Holding step high does not repeat.
  - Step edges are ignored while running, while armed, or while the synced deposit is high.
- Deposit:
  - dep_sw = dep_sync & idle & ~armed.
  - A falling edge of the gated dep_sw produces incp_db=1 for exactly 1 cycle.
  - If run starts, or the sequencer leaves idle while dep is held, dep_sw drops and no incp_db pulse is emitted.
- Reset (asynchronous, any time including mid-instruction): s0..s3=0, ws=0, phase=0, ALU counter=0, running=0, armed=0, dep_sw=0, incp_db=0, all synchronizer stages cleared. The interrupted instruction is abandoned.
- Output timing: all outputs are registered, with no combinational path from any input to any output.

Test Plan:
- Reset, then run_sw=1 held past sync, o2=1, deref=0 -> from the first FETCH, {s3..s0} per cycle = 0000,0000,0001,0001,0011,0011,0000 and ws = 0,1,0,1,0,1,0; running=1.
- o2=0, ALU_STEPS=4 -> sequence FETCH×2, DECODE×2, LOAD×2, 0100×6, 1000×2, back to 0000 at cycle 14; ws toggles 0/1 throughout.
- run_sw dropped during ALU step 1 -> remaining ALU states complete; the sequencer holds at 0000 with ws=0 and running=0 indefinitely.
- Idle, step_sw pulse held 20 cycles, o2=1 -> exactly one 6-cycle instruction runs, then idle; a second rising edge runs one more instruction.
- Idle, dep_sw_in high for 5 cycles -> dep_sw rises SYNC_STAGES cycles later. After dep_sw falls, incp_db is high for exactly 1 cycle. Repeating with run_sw=1 -> dep_sw and incp_db stay 0.
- rst pulsed during EXEC phase 1 -> s0..s3 and ws go to 0 immediately without waiting for clk. After release with run_sw=1, execution restarts at FETCH phase 0.
